// File: rtl/dmem_lsu_bridge.sv
// -----------------------------------------------------------------------------
// dmem_lsu_bridge
//   Upstream master for the dmem port of the memory controller. Turns a single
//   LSU load/store (RV32 funct3 size encoding) into one mem_* transaction:
//   stores get byte strobes and lane-replicated write data, loads get their
//   read word shifted down and sign/zero-extended. One access in flight.
//   Misaligned requests are answered without touching the bus, and any
//   handshake wait longer than p_TIMEOUT cycles is answered with an error.
//
//   Valid/ready rule on every channel here: a transfer happens in the cycle
//   where valid and ready are both high; while valid is high and ready is low
//   the sender holds valid and its payload unchanged.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   req_*             LSU request channel (valid/ready, cmd, funct3, addr, wdata)
//   resp_*            one-cycle completion pulse with load data / error flags
//   mem_valid/ready   command channel (mem_addr word aligned, mem_cmd, mem_size)
//   mem_w_*           write-data channel with strobes and error response
//   mem_r_*           read-data channel with error response
//   dbg_state         current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module dmem_lsu_bridge #(
    parameter int unsigned p_ADDR_BITS = 32,
    parameter int unsigned p_DATA_BITS = 32,
    parameter int unsigned p_STRB_BITS = 4,
    parameter int unsigned p_TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_cmd,
    input  logic [2:0]             req_funct3,
    input  logic [p_ADDR_BITS-1:0] req_addr,
    input  logic [p_DATA_BITS-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [p_DATA_BITS-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   resp_misalign,
    output logic [p_ADDR_BITS-1:0] mem_addr,
    output logic                   mem_cmd,
    output logic [1:0]             mem_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_w_valid,
    input  logic                   mem_w_ready,
    output logic [p_STRB_BITS-1:0] mem_w_strb,
    output logic [p_DATA_BITS-1:0] mem_w_data,
    input  logic                   mem_w_resp,
    output logic                   mem_r_ready,
    input  logic                   mem_r_valid,
    input  logic [p_DATA_BITS-1:0] mem_r_data,
    input  logic                   mem_r_resp,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Counter only has to reach p_TIMEOUT-1; the cycle after that is spent in RESP.
    localparam int unsigned CNT_W = (p_TIMEOUT > 1) ? $clog2(p_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((p_TIMEOUT > 0) ? p_TIMEOUT - 1 : 0);

    state_t                   state_q, state_d;
    logic                     cmd_q, cmd_d;
    logic [2:0]               f3_q, f3_d;
    logic [p_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [p_DATA_BITS-1:0]   wdata_q, wdata_d;
    logic                     w_done_q, w_done_d;   // write data already accepted while in CMD
    logic                     err_q, err_d;
    logic                     mis_q, mis_d;
    logic [p_DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [1:0]               req_size;
    logic                     req_misaligned;
    logic [p_STRB_BITS-1:0]   strb_raw;
    logic [p_DATA_BITS-1:0]   rd_shift;
    logic [p_DATA_BITS-1:0]   rd_ext;
    logic                     timeout_hit;
    logic                     waiting;
    logic                     w_hs;

    // Size from funct3[1:0]: 00 byte, 01 half, anything else (incl. reserved) word.
    always_comb begin
        req_size = 2'd2;
        if (req_funct3[1:0] == 2'b00)      req_size = 2'd0;
        else if (req_funct3[1:0] == 2'b01) req_size = 2'd1;
    end

    assign req_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                            ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    always_comb begin
        mem_size = 2'd2;
        if (f3_q[1:0] == 2'b00)      mem_size = 2'd0;
        else if (f3_q[1:0] == 2'b01) mem_size = 2'd1;
    end

    // Write lanes: data is replicated across the word so the strobe alone picks the lane.
    always_comb begin
        case (mem_size)
            2'd0: begin
                strb_raw   = 4'b0001 << addr_q[1:0];
                mem_w_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                strb_raw   = 4'b0011 << addr_q[1:0];
                mem_w_data = {2{wdata_q[15:0]}};
            end
            default: begin
                strb_raw   = 4'hF;
                mem_w_data = wdata_q;
            end
        endcase
    end

    // Loads present no strobes.
    assign mem_w_strb = cmd_q ? strb_raw : '0;
    assign mem_addr   = {addr_q[p_ADDR_BITS-1:2], 2'b00};
    assign mem_cmd    = cmd_q;
    assign dbg_state  = state_q;

    // Read alignment and extension; f3_q[2] selects zero extension.
    assign rd_shift = mem_r_data >> {addr_q[1:0], 3'b000};
    always_comb begin
        case (mem_size)
            2'd0:    rd_ext = {{24{~f3_q[2] & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = {{16{~f3_q[2] & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    assign waiting     = (state_q == S_CMD) || (state_q == S_WDATA) || (state_q == S_RDATA);
    // >= so a wait that crosses the limit during a partial handshake still ends.
    assign timeout_hit = (p_TIMEOUT != 0) && (cnt_q >= TO_LAST);

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        f3_d          = f3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        w_done_d      = w_done_q;
        err_d         = err_q;
        mis_d         = mis_q;
        rdata_d       = rdata_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_err      = 1'b0;
        resp_misalign = 1'b0;
        mem_valid     = 1'b0;
        mem_w_valid   = 1'b0;
        mem_r_ready   = 1'b0;
        w_hs          = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_d    = req_cmd;
                    f3_d     = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    w_done_d = 1'b0;
                    err_d    = 1'b0;
                    mis_d    = 1'b0;
                    rdata_d  = '0;
                    if (req_misaligned) begin
                        err_d   = 1'b1;
                        mis_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_CMD;
                    end
                end
            end
            S_CMD: begin
                mem_valid   = 1'b1;
                mem_w_valid = cmd_q && !w_done_q;
                w_hs        = mem_w_valid && mem_w_ready;
                if (mem_ready) begin
                    if (!cmd_q) begin
                        state_d = S_RDATA;
                    end else if (w_done_q || w_hs) begin
                        err_d   = err_q | (w_hs & mem_w_resp);
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WDATA;
                    end
                end else if (w_hs) begin
                    w_done_d = 1'b1;
                    err_d    = mem_w_resp;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WDATA: begin
                mem_w_valid = 1'b1;
                if (mem_w_ready) begin
                    err_d   = mem_w_resp;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RDATA: begin
                mem_r_ready = 1'b1;
                if (mem_r_valid) begin
                    err_d   = mem_r_resp;
                    rdata_d = mem_r_resp ? '0 : rd_ext;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid    = 1'b1;
                resp_rdata    = rdata_q;
                resp_err      = err_q;
                resp_misalign = mis_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter restarts whenever a new state is entered.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (waiting)       cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            w_done_q <= 1'b0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            w_done_q <= w_done_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
module tb_dmem_lsu_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_cmd;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_misalign;
    logic [31:0] mem_addr;
    logic        mem_cmd;
    logic [1:0]  mem_size;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_w_valid;
    logic        mem_w_ready;
    logic [3:0]  mem_w_strb;
    logic [31:0] mem_w_data;
    logic        mem_w_resp;
    logic        mem_r_ready;
    logic        mem_r_valid;
    logic [31:0] mem_r_data;
    logic        mem_r_resp;
    logic [2:0]  dbg_state;

    int vectors;
    int miscompares;

    dmem_lsu_bridge #(
        .p_ADDR_BITS(32), .p_DATA_BITS(32), .p_STRB_BITS(4), .p_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_misalign(resp_misalign),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data), .mem_w_resp(mem_w_resp),
        .mem_r_ready(mem_r_ready), .mem_r_valid(mem_r_valid),
        .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic cmd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_cmd    = cmd;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    // Zero-wait load; r_valid arrives the cycle after the command.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic rresp,
                           input logic [31:0] exp_rdata, input logic exp_err);
        mem_ready = 1'b1;
        issue(1'b0, f3, addr, 32'h0);
        check({tag, " cmd.valid"}, {31'b0, mem_valid}, 32'd1);
        check({tag, " cmd.addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, " cmd.rw"}, {31'b0, mem_cmd}, 32'd0);
        tick();
        check({tag, " r_ready"}, {31'b0, mem_r_ready}, 32'd1);
        mem_r_valid = 1'b1;
        mem_r_data  = word;
        mem_r_resp  = rresp;
        tick();
        mem_r_valid = 1'b0;
        mem_r_resp  = 1'b0;
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
        tick();
        check({tag, " back_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
    endtask

    // Zero-wait store: command and write data accepted in the same cycle.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_strb,
                            input logic [31:0] exp_data, input logic [1:0] exp_size);
        mem_ready   = 1'b1;
        mem_w_ready = 1'b1;
        issue(1'b1, f3, addr, wdata);
        check({tag, " valids"}, {30'b0, mem_valid, mem_w_valid}, 32'd3);
        check({tag, " strb"}, {28'b0, mem_w_strb}, {28'b0, exp_strb});
        check({tag, " wdata"}, mem_w_data, exp_data);
        check({tag, " size"}, {30'b0, mem_size}, {30'b0, exp_size});
        tick();
        check({tag, " resp"}, {29'b0, resp_valid, resp_err, resp_misalign}, 32'd4);
        check({tag, " rdata0"}, resp_rdata, 32'h0);
        tick();
        check({tag, " back_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_cmd     = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        mem_ready   = 1'b0;
        mem_w_ready = 1'b0;
        mem_w_resp  = 1'b0;
        mem_r_valid = 1'b0;
        mem_r_data  = 32'h0;
        mem_r_resp  = 1'b0;

        // reset
        tick();
        tick();
        check("rst.mem_valids", {29'b0, mem_valid, mem_w_valid, mem_r_ready}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_strb_data", {28'b0, mem_w_strb} | mem_w_data, 32'h0);
        check("rst.resp", {29'b0, resp_valid, resp_err, resp_misalign}, 32'd0);
        check("rst.state", {29'b0, dbg_state}, 32'd0);
        rst = 1'b1;
        tick();
        check("rst.req_ready", {31'b0, req_ready}, 32'd1);

        // loads
        do_load("lb",  3'b000, 32'h103, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 1'b0);
        do_load("lhu", 3'b101, 32'h102, 32'h8765_4321, 1'b0, 32'h0000_8765, 1'b0);
        do_load("lh",  3'b001, 32'h102, 32'h8765_4321, 1'b0, 32'hFFFF_8765, 1'b0);
        do_load("lbu", 3'b100, 32'h101, 32'h80FF_1234, 1'b0, 32'h0000_0012, 1'b0);
        do_load("lw",  3'b010, 32'h200, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
        do_load("lrsv", 3'b011, 32'h204, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0);
        do_load("lerr", 3'b010, 32'h300, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);

        // stores
        do_store("sb", 3'b000, 32'h101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 2'd0);
        do_store("sh", 3'b001, 32'h102, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF, 2'd1);
        do_store("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 2'd2);

        // misaligned word store: no bus activity, error next cycle
        mem_ready   = 1'b1;
        mem_w_ready = 1'b1;
        issue(1'b1, 3'b010, 32'h102, 32'h1111_2222);
        check("mis.no_bus", {30'b0, mem_valid, mem_w_valid}, 32'd0);
        check("mis.resp", {29'b0, resp_valid, resp_err, resp_misalign}, 32'd7);
        tick();
        check("mis.idle", {30'b0, resp_valid, req_ready}, 32'd1);

        // store with write data accepted 3+ cycles after the command
        mem_ready   = 1'b1;
        mem_w_ready = 1'b0;
        issue(1'b1, 3'b000, 32'h203, 32'h0000_005A);
        check("dly.cmd", {30'b0, mem_valid, mem_w_valid}, 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("dly.hold", {29'b0, mem_valid, mem_w_valid, resp_valid}, 32'd2);
            check("dly.strb", {28'b0, mem_w_strb}, 32'h8);
            check("dly.data", mem_w_data, 32'h5A5A_5A5A);
            tick();
        end
        mem_w_ready = 1'b1;
        check("dly.last", {31'b0, mem_w_valid}, 32'd1);
        tick();
        mem_w_ready = 1'b0;
        check("dly.resp", {29'b0, resp_valid, resp_err, resp_misalign}, 32'd4);
        tick();
        check("dly.single", {31'b0, resp_valid}, 32'd0);

        // write data accepted before the command, with a write error
        mem_ready   = 1'b0;
        mem_w_ready = 1'b1;
        mem_w_resp  = 1'b1;
        issue(1'b1, 3'b010, 32'h400, 32'h0BAD_0BAD);
        check("wfirst.both", {30'b0, mem_valid, mem_w_valid}, 32'd3);
        tick();
        mem_w_resp  = 1'b0;
        check("wfirst.drop_w", {30'b0, mem_valid, mem_w_valid}, 32'd2);
        mem_ready   = 1'b1;
        mem_w_ready = 1'b0;
        tick();
        check("wfirst.resp", {29'b0, resp_valid, resp_err, resp_misalign}, 32'd6);
        tick();

        // timeout on a load whose command is never accepted
        mem_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h500, 32'h0);
        seen = 0;
        for (int c = 1; c <= 300; c++) begin
            if (resp_valid) begin
                seen = c;
                break;
            end
            if (c == 255) check("to.still_cmd", {31'b0, mem_valid}, 32'd1);
            tick();
        end
        check("to.cycle", seen, 32'd256);
        check("to.resp", {28'b0, resp_valid, resp_err, resp_misalign, mem_valid}, 32'd12);
        tick();
        check("to.idle", {31'b0, req_ready}, 32'd1);

        // late read data in IDLE is not accepted
        mem_r_valid = 1'b1;
        mem_r_data  = 32'hFFFF_FFFF;
        check("late.r_ready", {31'b0, mem_r_ready}, 32'd0);
        tick();
        check("late.idle", {30'b0, resp_valid, req_ready}, 32'd1);
        mem_r_valid = 1'b0;

        // reset in the middle of a transaction
        mem_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h600, 32'h0);
        check("mrst.cmd", {31'b0, mem_valid}, 32'd1);
        rst = 1'b0;
        #2;
        check("mrst.async", {29'b0, mem_valid, req_ready, resp_valid}, 32'd2);
        rst = 1'b1;
        tick();
        check("mrst.no_resp", {30'b0, resp_valid, req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
